// File: rtl/ready_registrar_if.sv
// Menu-side bundle for the ready registrar: raw buttons and menu state in,
// per-player ready flags and the activity pulse out.
interface ready_registrar_if;
    logic       is_in_menu;
    logic [2:0] countdown;
    logic       green_btn;
    logic       red_btn;
    logic       blue_btn;
    logic       yellow_btn;
    logic       green_ready_to_play;
    logic       red_ready_to_play;
    logic       blue_ready_to_play;
    logic       yellow_ready_to_play;
    logic       activity;

    modport master (
        output is_in_menu, countdown,
        output green_btn, red_btn, blue_btn, yellow_btn,
        input  green_ready_to_play, red_ready_to_play,
        input  blue_ready_to_play, yellow_ready_to_play,
        input  activity
    );

    modport slave (
        input  is_in_menu, countdown,
        input  green_btn, red_btn, blue_btn, yellow_btn,
        output green_ready_to_play, red_ready_to_play,
        output blue_ready_to_play, yellow_ready_to_play,
        output activity
    );
endinterface

// File: rtl/ready_registrar.sv
// Four-player ready registrar: synchronize and debounce each button, toggle the
// player's ready flag on a clean press while the menu is open and unlocked.
module ready_registrar #(
    parameter int DEBOUNCE_CLK_COUNT = 500000
) (
    input  logic              clk,
    input  logic              reset,
    ready_registrar_if.slave  bus
);

    localparam int CW = (DEBOUNCE_CLK_COUNT > 2) ? $clog2(DEBOUNCE_CLK_COUNT) : 1;
    localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CLK_COUNT - 1);

    // Channel index: 0 green, 1 red, 2 blue, 3 yellow.
    logic [3:0]    btn_raw;
    logic [3:0]    s1_q;
    logic [3:0]    s2_q;
    logic [3:0]    deb_q;
    logic [3:0]    deb_d;
    logic [3:0]    press_q;
    logic [3:0]    press_d;
    logic [3:0]    ready_q;
    logic [3:0]    ready_d;
    logic          activity_q;
    logic          activity_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic          unlocked;

    assign btn_raw  = {bus.yellow_btn, bus.blue_btn, bus.red_btn, bus.green_btn};
    assign unlocked = bus.is_in_menu && (bus.countdown == 3'd0);

    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == TERM_CNT) begin
                deb_d[i]   = s2_q[i];
                cnt_d[i]   = '0;
                press_d[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Presses that complete during the lock window are dropped, not queued.
    always_comb begin
        ready_d    = ready_q ^ (press_q & {4{unlocked}});
        activity_d = |(ready_d ^ ready_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            press_q    <= '0;
            ready_q    <= '0;
            activity_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= btn_raw;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            press_q    <= press_d;
            ready_q    <= ready_d;
            activity_q <= activity_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.green_ready_to_play  = ready_q[0];
    assign bus.red_ready_to_play    = ready_q[1];
    assign bus.blue_ready_to_play   = ready_q[2];
    assign bus.yellow_ready_to_play = ready_q[3];
    assign bus.activity             = activity_q;

endmodule

// File: tb/tb_ready_registrar.sv
// Directed bench for ready_registrar with a 4-cycle debounce: press latency,
// glitch rejection, toggling, simultaneous presses, lock window and reset abort.
module tb_ready_registrar;
    localparam int DB = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   pulses;

    ready_registrar_if rr_if ();

    ready_registrar #(.DEBOUNCE_CLK_COUNT(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven 1 time unit after an edge, so they are first sampled
    // on the following edge; a held press shows on ready 2+DB+1 edges later.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {rr_if.yellow_ready_to_play, rr_if.blue_ready_to_play,
                rr_if.red_ready_to_play, rr_if.green_ready_to_play};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        rr_if.is_in_menu = 1'b1;
        rr_if.countdown  = 3'd0;
        rr_if.green_btn  = 1'b0;
        rr_if.red_btn    = 1'b0;
        rr_if.blue_btn   = 1'b0;
        rr_if.yellow_btn = 1'b0;
        tick(2);
        check("reset_flags", 32'(flags()), 32'h0);
        check("reset_activity", 32'(rr_if.activity), 32'h0);
        reset = 1'b0;
        tick(2);

        // Green held: toggles exactly 2+DB+1 edges after being driven.
        rr_if.green_btn = 1'b1;
        tick(2 + DB);
        check("green_early", 32'(flags()), 32'h0);
        check("green_early_act", 32'(rr_if.activity), 32'h0);
        tick(1);
        check("green_rise", 32'(flags()), 32'h1);
        check("green_rise_act", 32'(rr_if.activity), 32'h1);
        tick(1);
        check("green_act_one_cycle", 32'(rr_if.activity), 32'h0);
        rr_if.green_btn = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        check("green_release_no_act", 32'(pulses), 32'h0);
        check("green_release_hold", 32'(flags()), 32'h1);

        // Red glitch of 3 cycles is rejected; a 10-cycle hold toggles once.
        rr_if.red_btn = 1'b1;
        tick(3);
        rr_if.red_btn = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        check("red_glitch_act", 32'(pulses), 32'h0);
        check("red_glitch_flags", 32'(flags()), 32'h1);
        rr_if.red_btn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        rr_if.red_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        check("red_hold_pulses", 32'(pulses), 32'h1);
        check("red_hold_flags", 32'(flags()), 32'h3);

        // Blue press, release, re-press: 1 then back to 0, one pulse per press.
        rr_if.blue_btn = 1'b1;
        tick(2 + DB + 1);
        check("blue_set", 32'(flags()), 32'h7);
        check("blue_set_act", 32'(rr_if.activity), 32'h1);
        tick(1);
        rr_if.blue_btn = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        check("blue_release_no_act", 32'(pulses), 32'h0);
        rr_if.blue_btn = 1'b1;
        tick(2 + DB + 1);
        check("blue_clear", 32'(flags()), 32'h3);
        check("blue_clear_act", 32'(rr_if.activity), 32'h1);
        tick(1);
        rr_if.blue_btn = 1'b0;
        tick(10);

        // Green and yellow on the same edge: both toggle together, single pulse.
        rr_if.green_btn  = 1'b1;
        rr_if.yellow_btn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 + DB; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        tick(1);
        check("gy_flags", 32'(flags()), 32'hA);
        pulses += int'(rr_if.activity);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        check("gy_single_pulse", 32'(pulses), 32'h1);
        rr_if.green_btn  = 1'b0;
        rr_if.yellow_btn = 1'b0;
        tick(10);

        // Green back to 1, then presses during countdown / outside menu are dropped.
        rr_if.green_btn = 1'b1;
        tick(2 + DB + 1);
        check("green_reset_to_1", 32'(flags()), 32'hB);
        rr_if.green_btn = 1'b0;
        tick(10);
        rr_if.countdown = 3'd5;
        rr_if.green_btn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        // Held through lock release: no second toggle without a new press.
        rr_if.countdown = 3'd0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        check("countdown_lock_flags", 32'(flags()), 32'hB);
        check("countdown_lock_act", 32'(pulses), 32'h0);
        rr_if.green_btn = 1'b0;
        tick(10);
        rr_if.is_in_menu = 1'b0;
        rr_if.green_btn  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(rr_if.activity);
        end
        rr_if.green_btn = 1'b0;
        tick(10);
        check("menu_lock_flags", 32'(flags()), 32'hB);
        check("menu_lock_act", 32'(pulses), 32'h0);
        rr_if.is_in_menu = 1'b1;
        tick(2);
        check("menu_return_hold", 32'(flags()), 32'hB);

        // All four set, then reset while green is mid-debounce (counter = 2).
        rr_if.blue_btn = 1'b1;
        tick(2 + DB + 1);
        check("all_set", 32'(flags()), 32'hF);
        rr_if.blue_btn = 1'b0;
        tick(10);
        rr_if.green_btn = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("mid_reset_flags", 32'(flags()), 32'h0);
        check("mid_reset_act", 32'(rr_if.activity), 32'h0);
        reset = 1'b0;
        tick(2 + DB);
        check("post_reset_early", 32'(flags()), 32'h0);
        tick(1);
        check("post_reset_rise", 32'(flags()), 32'h1);
        check("post_reset_act", 32'(rr_if.activity), 32'h1);
        rr_if.green_btn = 1'b0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ready_registrar.md
Name: ready_registrar

Overview:
- Produces the four per-player ready_to_play flags that the menu manager consumes to trigger the start countdown.
- Synchronizes and debounces one raw push-button per player (green, red, blue, yellow).
- A clean press toggles that player's ready flag while the menu is open and the countdown has not started.
- Flags freeze once the countdown runs or the race starts; reset clears everything.

Parameters:
DEBOUNCE_CLK_COUNT, 500000, clk cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz); legal minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
is_in_menu  input  1  high while game is in menu (from menu manager)
countdown  input  3  menu countdown value; 0 = not started
green_btn  input  1  raw async button, high = pressed
red_btn  input  1  raw async button
blue_btn  input  1  raw async button
yellow_btn  input  1  raw async button
green_ready_to_play  output  1  registered ready flag
red_ready_to_play  output  1  registered ready flag
blue_ready_to_play  output  1  registered ready flag
yellow_ready_to_play  output  1  registered ready flag
activity  output  1  one-cycle pulse when any ready flag changes

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled on posedge clk. Reset clears all sync flops, debounce counters, debounced levels, press pulses, all four ready outputs and activity to 0.
- Reset mid-debounce or mid-toggle aborts the operation. No pending event survives reset.
- Four identical, independent per-player channels. Each channel has:
  - 2-flop synchronizer s1 -> s2.
  - Debounce counter, width ceil(log2(DEBOUNCE_CLK_COUNT)).
  - Debounced level deb and registered press pulse.
- Debounce rules:
  - If s2 == deb: counter <= 0.
  - Else if counter == DEBOUNCE_CLK_COUNT-1: deb <= s2, counter <= 0, press <= s2. The pulse fires only on a 0->1 transition.
  - Else: counter <= counter + 1.
  - press defaults to 0 every cycle; it is a one-cycle pulse.
  - A glitch shorter than DEBOUNCE_CLK_COUNT cycles at s2 never changes deb.
- Toggle rules, per channel, on the cycle after press:
  - If is_in_menu == 1 and countdown == 0: ready <= ~ready.
  - Otherwise the press is ignored and ready holds.
  - Release (deb 1->0) never changes ready.
- Latency: button stable high, first sampled high at edge N. Then s1=1 at N, s2=1 at N+1, deb and press at N+1+DEBOUNCE_CLK_COUNT, ready toggles at N+2+DEBOUNCE_CLK_COUNT.
- activity is registered: high for exactly the one cycle in which at least one ready output has just changed. Simultaneous toggles on several channels give a single one-cycle pulse.
- Lock window: while countdown != 0 or is_in_menu == 0, flags hold their value indefinitely; no auto-clear.
- When is_in_menu returns to 1 (after a game reset), flags keep their held value until toggled or reset.
- Debouncing continues during lock. A press completing during lock is discarded, not queued.
- Simultaneous presses on different channels in the same cycle are all applied in that cycle.
- A button held through lock-release does not toggle again; a new press requires release then re-press.
- No combinational path from any input to any output.

Test Plan:
- DEBOUNCE_CLK_COUNT=4, is_in_menu=1, countdown=0. green_btn held high from edge 0 -> green_ready_to_play rises after edge 7. activity high only in cycle 7-8. Other flags stay 0.
- Same setup, red_btn pulsed high for 3 cycles then low -> red_ready_to_play stays 0 and activity never fires. Then hold red for 10 cycles -> red flag toggles to 1 exactly once.
- Blue pressed (flag -> 1), released 10 cycles, pressed again -> flag returns to 0. Each press produces exactly one activity pulse; releases produce none.
- Green and yellow pressed on the same edge -> both flags rise on the same cycle with a single one-cycle activity pulse.
- Set green flag to 1, drive countdown=5, press green -> flag stays 1, no activity. Set is_in_menu=0, countdown=0, press again -> still 1.
- All four flags set, green press mid-debounce (counter=2), assert reset for 1 cycle -> all outputs 0 the next cycle. Green held high afterward needs a full 2+DEBOUNCE_CLK_COUNT+1 cycles before toggling.
